// File: rtl/snd_pkg.sv
// Shared constants and lookup tables for the sound sequencer: mode codes,
// tone codes, tone half-periods and the per-mode note ROM.
package snd_pkg;

    localparam logic [2:0] SND_STOP   = 3'd0;
    localparam logic [2:0] SND_COUNT  = 3'd1;
    localparam logic [2:0] SND_START  = 3'd2;
    localparam logic [2:0] SND_HIT    = 3'd3;
    localparam logic [2:0] SND_MISS   = 3'd4;
    localparam logic [2:0] SND_SCLEAR = 3'd5;
    localparam logic [2:0] SND_GOVER  = 3'd6;
    localparam logic [2:0] SND_GCLEAR = 3'd7;

    localparam logic [3:0] TONE_REST = 4'd0;
    localparam logic [3:0] TONE_C4   = 4'd1;
    localparam logic [3:0] TONE_E4   = 4'd2;
    localparam logic [3:0] TONE_G4   = 4'd3;
    localparam logic [3:0] TONE_C5   = 4'd4;
    localparam logic [3:0] TONE_E5   = 4'd5;
    localparam logic [3:0] TONE_G5   = 4'd6;
    localparam logic [3:0] TONE_C6   = 4'd7;
    localparam logic [3:0] TONE_END  = 4'd15;

    typedef struct packed {
        logic [3:0] tone;
        logic [8:0] dur_ms;
    } note_t;

    typedef enum logic [1:0] {IDLE, TONE, NEXT} seq_state_t;

    // Half-period in clocks; zero means silence (rest, end marker, unused codes).
    function automatic logic [10:0] half_period(input logic [3:0] tone);
        case (tone)
            TONE_C4: return 11'd1911;
            TONE_E4: return 11'd1517;
            TONE_G4: return 11'd1276;
            TONE_C5: return 11'd956;
            TONE_E5: return 11'd758;
            TONE_G5: return 11'd638;
            TONE_C6: return 11'd478;
            default: return 11'd0;
        endcase
    endfunction

    function automatic note_t mk_note(input logic [3:0] tone, input logic [8:0] dur_ms);
        note_t n;
        n.tone   = tone;
        n.dur_ms = dur_ms;
        return n;
    endfunction

    // Any index past the last note of a sequence reads as the end marker.
    function automatic note_t note_rom(input logic [2:0] mode, input logic [2:0] idx);
        note_t n;
        n = mk_note(TONE_END, 9'd0);
        case (mode)
            SND_COUNT: if (idx == 3'd0) n = mk_note(TONE_C5, 9'd100);
            SND_START: if (idx == 3'd0) n = mk_note(TONE_C6, 9'd300);
            SND_HIT: begin
                if (idx == 3'd0) n = mk_note(TONE_E5, 9'd50);
                if (idx == 3'd1) n = mk_note(TONE_G5, 9'd50);
            end
            SND_MISS: begin
                if (idx == 3'd0) n = mk_note(TONE_G4, 9'd80);
                if (idx == 3'd1) n = mk_note(TONE_C4, 9'd120);
            end
            SND_SCLEAR: begin
                if (idx == 3'd0) n = mk_note(TONE_C5, 9'd100);
                if (idx == 3'd1) n = mk_note(TONE_E5, 9'd100);
                if (idx == 3'd2) n = mk_note(TONE_G5, 9'd100);
                if (idx == 3'd3) n = mk_note(TONE_C6, 9'd200);
            end
            SND_GOVER: begin
                if (idx == 3'd0) n = mk_note(TONE_G4, 9'd150);
                if (idx == 3'd1) n = mk_note(TONE_REST, 9'd50);
                if (idx == 3'd2) n = mk_note(TONE_E4, 9'd150);
                if (idx == 3'd3) n = mk_note(TONE_C4, 9'd300);
            end
            SND_GCLEAR: begin
                if (idx == 3'd0) n = mk_note(TONE_C5, 9'd100);
                if (idx == 3'd1) n = mk_note(TONE_E5, 9'd100);
                if (idx == 3'd2) n = mk_note(TONE_G5, 9'd100);
                if (idx == 3'd3) n = mk_note(TONE_C6, 9'd100);
                if (idx == 3'd4) n = mk_note(TONE_REST, 9'd50);
                if (idx == 3'd5) n = mk_note(TONE_C6, 9'd300);
            end
            default: n = mk_note(TONE_END, 9'd0);
        endcase
        return n;
    endfunction

endpackage

// File: rtl/tone_gen.sv
// Square-wave generator: toggles every half_period clocks after a load;
// a zero half-period holds the output low.
module tone_gen (
    input  logic        clk_1mhz,
    input  logic        rst_n,
    input  logic [10:0] half_period,
    input  logic        load,
    output logic        square
);

    logic [10:0] cnt_q;

    always_ff @(posedge clk_1mhz or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            square <= 1'b0;
        end else if (load || half_period == 11'd0) begin
            cnt_q  <= '0;
            square <= 1'b0;
        end else if (cnt_q == half_period - 11'd1) begin
            cnt_q  <= '0;
            square <= ~square;
        end else begin
            cnt_q <= cnt_q + 11'd1;
        end
    end

endmodule

// File: rtl/snd_seq.sv
// Piezo sound sequencer: plays the note list of the requested mode, timing
// each note in milliseconds from a clock prescaler.
module snd_seq
    import snd_pkg::*;
#(
    parameter int CLK_HZ = 1000000
) (
    input  logic       clk_1mhz,
    input  logic       rst_n,
    input  logic [2:0] snd_mode,
    input  logic       trig,
    output logic       playing,
    output logic       piezo_out
);

    localparam int         MS_DIV    = CLK_HZ / 1000;
    localparam logic [9:0] PRESC_MAX = 10'(MS_DIV - 1);

    seq_state_t  state_q, state_d;
    logic [2:0]  mode_q, mode_d;
    logic [2:0]  idx_q, idx_d;
    logic [9:0]  presc_q;
    logic [8:0]  ms_q;
    logic        start, abort, load, expire, last, active;
    note_t       cur;
    logic [10:0] hp;

    assign cur     = note_rom(mode_q, idx_q);
    assign start   = trig && (snd_mode != SND_STOP);
    assign abort   = trig && (snd_mode == SND_STOP);
    assign expire  = (state_q == TONE) && (ms_q == cur.dur_ms);
    assign last    = (cur.tone == TONE_END);
    assign active  = (state_q != IDLE);
    assign playing = rst_n & (active | start);
    assign hp      = (state_q == TONE) ? half_period(cur.tone) : 11'd0;

    // A trigger outranks everything else, including a note expiring this cycle.
    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        idx_d   = idx_q;
        load    = 1'b0;
        if (start) begin
            state_d = TONE;
            mode_d  = snd_mode;
            idx_d   = 3'd0;
            load    = 1'b1;
        end else if (abort) begin
            state_d = IDLE;
            mode_d  = SND_STOP;
            idx_d   = 3'd0;
            load    = 1'b1;
        end else begin
            case (state_q)
                IDLE: ;
                TONE: begin
                    if (expire) begin
                        state_d = NEXT;
                        idx_d   = idx_q + 3'd1;
                    end
                end
                NEXT: begin
                    if (last) begin
                        state_d = IDLE;
                        mode_d  = SND_STOP;
                        idx_d   = 3'd0;
                    end else begin
                        state_d = TONE;
                        load    = 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_1mhz or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            mode_q  <= SND_STOP;
            idx_q   <= '0;
            presc_q <= '0;
            ms_q    <= '0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            idx_q   <= idx_d;
            if (load || state_q != TONE) begin
                presc_q <= '0;
                ms_q    <= '0;
            end else if (presc_q == PRESC_MAX) begin
                presc_q <= '0;
                ms_q    <= ms_q + 9'd1;
            end else begin
                presc_q <= presc_q + 10'd1;
            end
        end
    end

    tone_gen u_tone_gen (
        .clk_1mhz    (clk_1mhz),
        .rst_n       (rst_n),
        .half_period (hp),
        .load        (load),
        .square      (piezo_out)
    );

endmodule

// File: tb/tb_snd_seq.sv
// Directed bench for snd_seq, run at a reduced CLK_HZ so 1 ms = 40 clocks;
// busy durations go through an expected queue checked by a monitor.
module tb_snd_seq;

    localparam int CLK_HZ = 40000;
    localparam int DIV    = CLK_HZ / 1000;

    logic       clk_1mhz = 1'b0;
    logic       rst_n    = 1'b0;
    logic       trig     = 1'b0;
    logic [2:0] snd_mode = 3'd0;
    logic       playing;
    logic       piezo_out;

    snd_seq #(.CLK_HZ(CLK_HZ)) dut (
        .clk_1mhz  (clk_1mhz),
        .rst_n     (rst_n),
        .snd_mode  (snd_mode),
        .trig      (trig),
        .playing   (playing),
        .piezo_out (piezo_out)
    );

    // clock / cycle counter
    always #5 clk_1mhz = ~clk_1mhz;

    int cyc = 0;
    always @(posedge clk_1mhz) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;
    logic [16:0] exp_q[$];
    logic [16:0] tol_q[$];

    task automatic check(input string name, input int act, input int exp, input int tol);
        int d;
        checks++;
        d = act - exp;
        if (d < 0) d = -d;
        if (d > tol) begin
            errors++;
            $display("FAIL %s: got %0d, want %0d (+/- %0d)", name, act, exp, tol);
        end
    endtask

    // monitor: busy length in cycles, from the edge taking trig to the edge playing drops
    bit prev_play = 1'b0;
    int busy      = 0;
    always @(negedge clk_1mhz) begin
        if (!rst_n) begin
            prev_play = 1'b0;
            busy      = 0;
        end else begin
            if (playing && !prev_play) begin
                busy = 0;
            end else if (playing) begin
                busy++;
            end else if (prev_play) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL busy_end: got end after %0d cycles, want no end", busy);
                end else begin
                    logic [16:0] e;
                    logic [16:0] t;
                    e = exp_q.pop_front();
                    t = tol_q.pop_front();
                    check("busy_time", busy, int'(e), int'(t));
                end
            end
            prev_play = playing;
        end
    end

    // driver tasks
    task automatic pulse_trig(input logic [2:0] mode);
        @(posedge clk_1mhz);
        #1;
        snd_mode = mode;
        trig     = 1'b1;
        #1;
        if (mode != 3'd0) check("playing_same_cycle", int'(playing), 1, 0);
        @(posedge clk_1mhz);
        #1;
        trig = 1'b0;
    endtask

    task automatic expect_busy(input int cycles, input int tol);
        exp_q.push_back(17'(cycles));
        tol_q.push_back(17'(tol));
    endtask

    task automatic wait_idle(input int limit);
        bit done;
        done = 1'b0;
        for (int i = 0; i < limit && !done; i++) begin
            @(negedge clk_1mhz);
            if (!playing) done = 1'b1;
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL idle_timeout: playing=1 after %0d cycles, want 0", limit);
        end
        repeat (3) @(negedge clk_1mhz);
    endtask

    task automatic find_rise(input int t0, input int limit, output int t);
        bit prev;
        prev = piezo_out;
        t = -1;
        for (int i = 0; i < limit && t < 0; i++) begin
            @(negedge clk_1mhz);
            if (piezo_out && !prev) t = cyc - t0;
            prev = piezo_out;
        end
    endtask

    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation still running, want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int t0, r1, r2, bad;
        bit saw_tone;

        // reset: busy stays low even with trig asserted
        rst_n    = 1'b0;
        trig     = 1'b1;
        snd_mode = 3'd1;
        #23;
        check("rst_playing", int'(playing), 0, 0);
        check("rst_piezo", int'(piezo_out), 0, 0);
        trig     = 1'b0;
        snd_mode = 3'd0;
        @(negedge clk_1mhz);
        rst_n = 1'b1;
        repeat (5) @(negedge clk_1mhz);
        check("idle_after_rst", int'(playing), 0, 0);

        // count beep: C5 100 ms, half-period 956
        expect_busy(100 * DIV, 2);
        pulse_trig(3'd1);
        t0 = cyc;
        find_rise(t0, 3000, r1);
        check("first_toggle", r1, 956, 0);
        find_rise(t0, 3000, r2);
        check("piezo_period", r2 - r1, 1912, 2);
        wait_idle(6000);

        // retrigger hit after 20 ms: busy 20 + 100 ms without a gap
        expect_busy(120 * DIV, 4);
        pulse_trig(3'd3);
        repeat (20 * DIV - 2) @(posedge clk_1mhz);
        #2;
        check("busy_before_retrig", int'(playing), 1, 0);
        pulse_trig(3'd3);
        wait_idle(8000);

        // game over: rest from 150 ms to 200 ms must be silent
        expect_busy(650 * DIV, 8);
        pulse_trig(3'd6);
        t0 = cyc;
        saw_tone = 1'b0;
        bad = 0;
        while (cyc - t0 < 200 * DIV) begin
            @(negedge clk_1mhz);
            if (cyc - t0 < 150 * DIV && piezo_out) saw_tone = 1'b1;
            if (cyc - t0 >= 150 * DIV + 4 && piezo_out) bad++;
        end
        check("tone_before_rest", int'(saw_tone), 1, 0);
        check("rest_silent", bad, 0, 0);
        wait_idle(30000);

        // game clear aborted with mode 0 at 250 ms
        expect_busy(250 * DIV, 2);
        pulse_trig(3'd7);
        repeat (250 * DIV - 2) @(posedge clk_1mhz);
        pulse_trig(3'd0);
        check("abort_piezo", int'(piezo_out), 0, 0);
        check("abort_playing", int'(playing), 0, 0);
        repeat (5) @(negedge clk_1mhz);

        // reset pulled during stage clear while the piezo is high
        pulse_trig(3'd5);
        repeat (5000) @(posedge clk_1mhz);
        for (int i = 0; i < 2000 && !piezo_out; i++) @(negedge clk_1mhz);
        check("piezo_before_rst", int'(piezo_out), 1, 0);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_mid_piezo", int'(piezo_out), 0, 0);
        check("rst_mid_playing", int'(playing), 0, 0);
        repeat (3) @(negedge clk_1mhz);
        rst_n = 1'b1;
        bad = 0;
        repeat (2000) begin
            @(negedge clk_1mhz);
            if (piezo_out || playing) bad++;
        end
        check("silent_after_rst", bad, 0, 0);

        // caller handshake: busy visible on the first sample after the trig edge
        expect_busy(200 * DIV, 4);
        pulse_trig(3'd4);
        @(negedge clk_1mhz);
        check("handshake_busy", int'(playing), 1, 0);
        wait_idle(10000);

        repeat (5) @(negedge clk_1mhz);
        check("scoreboard_drained", exp_q.size(), 0, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
